// File: rtl/diff_accum.sv
// Frame accumulator: sums a run of signed difference words with saturation
// and hands the result downstream through a valid/ready hold stage.
module diff_accum #(
    parameter int DATAWIDTH = 32,
    parameter int ACCWIDTH  = 40,
    parameter int CNTWIDTH  = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATAWIDTH-1:0] diff,
    input  logic                 diff_valid,
    output logic                 diff_ready,
    input  logic                 start,
    input  logic [CNTWIDTH-1:0]  len,
    output logic [ACCWIDTH-1:0]  sum,
    output logic                 sum_valid,
    input  logic                 sum_ready,
    output logic                 busy,
    output logic                 ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic signed [ACCWIDTH-1:0]  acc_q, acc_d;
    logic signed [ACCWIDTH-1:0]  sum_q, sum_d;
    logic        [CNTWIDTH-1:0]  cnt_q, cnt_d;
    logic                        ovf_q, ovf_d;

    logic                        accept;
    logic signed [ACCWIDTH-1:0]  diff_ext;
    logic        [ACCWIDTH:0]    sat_res;
    logic signed [ACCWIDTH-1:0]  add_val;
    logic                        add_ovf;

    function automatic logic signed [ACCWIDTH-1:0] sign_ext(input logic [DATAWIDTH-1:0] d);
        logic signed [ACCWIDTH-1:0] r;
        for (int i = 0; i < ACCWIDTH; i++) begin
            r[i] = (i < DATAWIDTH) ? d[i] : d[DATAWIDTH-1];
        end
        return r;
    endfunction

    // Returns {overflow_flag, clamped_sum}.
    function automatic logic [ACCWIDTH:0] sat_add(input logic signed [ACCWIDTH-1:0] a,
                                                  input logic signed [ACCWIDTH-1:0] b);
        logic signed [ACCWIDTH:0]   wide;
        logic signed [ACCWIDTH-1:0] max_pos;
        logic signed [ACCWIDTH-1:0] max_neg;
        max_pos = {1'b0, {(ACCWIDTH-1){1'b1}}};
        max_neg = {1'b1, {(ACCWIDTH-1){1'b0}}};
        wide    = {a[ACCWIDTH-1], a} + {b[ACCWIDTH-1], b};
        if (wide[ACCWIDTH] != wide[ACCWIDTH-1]) begin
            return wide[ACCWIDTH] ? {1'b1, max_neg} : {1'b1, max_pos};
        end
        return {1'b0, wide[ACCWIDTH-1:0]};
    endfunction

    assign diff_ext = sign_ext(diff);
    assign sat_res  = sat_add(acc_q, diff_ext);
    assign add_val  = sat_res[ACCWIDTH-1:0];
    assign add_ovf  = sat_res[ACCWIDTH];

    assign diff_ready = (state_q == ACCUM);
    assign sum_valid  = (state_q == HOLD);
    assign busy       = (state_q != IDLE);
    assign sum        = sum_q;
    assign ovf        = ovf_q;
    assign accept     = diff_valid && diff_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start && (len != '0)) begin
                    state_d = ACCUM;
                    cnt_d   = len;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = add_val;
                    if (add_ovf) begin
                        ovf_d = 1'b1;
                    end
                    // Count stops at zero; the final sample latches the result.
                    if (cnt_q <= 1) begin
                        cnt_d   = '0;
                        sum_d   = add_val;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            HOLD: begin
                if (sum_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_diff_accum.sv
// Randomized and directed bench for diff_accum against a saturating
// integer reference model of the frame sum.
module tb_diff_accum;

    localparam int DW = 32;
    localparam int AW = 33;
    localparam int CW = 8;
    localparam longint MAXP = (64'sd1 <<< (AW-1)) - 1;
    localparam longint MINN = -(64'sd1 <<< (AW-1));

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic [DW-1:0] diff = '0;
    logic          diff_valid = 1'b0;
    logic          diff_ready;
    logic          start = 1'b0;
    logic [CW-1:0] len = '0;
    logic [AW-1:0] sum;
    logic          sum_valid;
    logic          sum_ready = 1'b0;
    logic          busy;
    logic          ovf;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] dq[$];
    bit            vq[$];
    longint        exp_sum = 0;
    bit            exp_ovf = 1'b0;

    diff_accum #(.DATAWIDTH(DW), .ACCWIDTH(AW), .CNTWIDTH(CW)) dut (
        .Clk(Clk), .Rst(Rst), .diff(diff), .diff_valid(diff_valid),
        .diff_ready(diff_ready), .start(start), .len(len), .sum(sum),
        .sum_valid(sum_valid), .sum_ready(sum_ready), .busy(busy), .ovf(ovf)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint sum_s();
        longint r;
        r = $signed(sum);
        return r;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input longint d, input bit v);
        dq.push_back(d[DW-1:0]);
        vq.push_back(v);
    endtask

    task automatic run_frame(input int L, input bit poke);
        longint acc;
        longint d;
        bit     ov;
        int     n;
        acc = 0; ov = 1'b0; n = 0;
        start = 1'b1;
        len   = L[CW-1:0];
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_ovf_clr", ovf, 0);
        while (n < L) begin
            if (dq.size() == 0 || vq.size() == 0) begin
                chk("frame_accepts", n, L);
                break;
            end
            diff       = dq.pop_front();
            diff_valid = vq.pop_front();
            if (poke) begin
                start     = ($urandom_range(0, 2) == 0);
                len       = CW'($urandom);
                sum_ready = $urandom_range(0, 1);
            end
            chk("accum_ready", diff_ready, 1);
            chk("accum_sum_valid", sum_valid, 0);
            if (diff_valid) begin
                d   = $signed(diff);
                acc = acc + d;
                if (acc > MAXP) begin acc = MAXP; ov = 1'b1; end
                else if (acc < MINN) begin acc = MINN; ov = 1'b1; end
                n++;
            end
            tick();
        end
        start = 1'b0; diff_valid = 1'b0; sum_ready = 1'b0;
        exp_sum = acc;
        exp_ovf = ov;
        chk("done_sum_valid", sum_valid, 1);
        chk("done_sum", sum_s(), exp_sum);
        chk("done_ovf", ovf, exp_ovf);
        chk("done_ready", diff_ready, 0);
        chk("done_busy", busy, 1);
        dq.delete();
        vq.delete();
    endtask

    task automatic finish_frame(input int hold);
        repeat (hold) begin
            start = $urandom_range(0, 1);
            len   = CW'($urandom);
            tick();
            chk("hold_valid", sum_valid, 1);
            chk("hold_sum", sum_s(), exp_sum);
        end
        start = 1'b0;
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
        chk("idle_valid", sum_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_sum", sum_s(), exp_sum);
        chk("idle_ovf", ovf, exp_ovf);
    endtask

    initial begin
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_ready", diff_ready, 0);
        chk("rst_valid", sum_valid, 0);
        chk("rst_sum", sum_s(), 0);
        chk("rst_ovf", ovf, 0);
        Rst = 1'b1;
        tick();

        // Basic four-sample frame
        push(5, 1); push(-3, 1); push(10, 1); push(2, 1);
        run_frame(4, 1'b0);
        chk("r33_sum", sum_s(), 14);
        finish_frame(1);

        // Gapped valid pattern, long hold
        push(1, 1); push(0, 0); push(0, 0); push(2, 1); push(0, 0); push(3, 1);
        run_frame(3, 1'b0);
        chk("r34_sum", sum_s(), 6);
        finish_frame(5);

        // Negative saturation
        repeat (3) push(64'sh8000_0000 - 64'sh1_0000_0000, 1);
        run_frame(3, 1'b0);
        chk("sat_neg", sum_s(), MINN);
        finish_frame(0);

        // Positive saturation
        repeat (3) push(64'sh7FFF_FFFF, 1);
        run_frame(3, 1'b0);
        chk("sat_pos", sum_s(), MAXP);
        chk("sat_ovf", ovf, 1);
        finish_frame(2);

        // Zero-length start is ignored
        start = 1'b1; len = '0;
        tick();
        start = 1'b0;
        chk("len0_busy", busy, 0);
        chk("len0_ready", diff_ready, 0);
        chk("len0_sum", sum_s(), exp_sum);
        chk("len0_ovf", ovf, exp_ovf);
        tick();
        chk("len0_busy2", busy, 0);

        // Restart attempts during the frame
        push(7, 1); push(8, 1);
        run_frame(2, 1'b1);
        finish_frame(1);

        // Asynchronous reset mid-frame
        start = 1'b1; len = 8'd5;
        tick();
        start = 1'b0; diff = 32'd4; diff_valid = 1'b1;
        tick(); tick();
        diff_valid = 1'b0;
        chk("pre_rst_busy", busy, 1);
        #2 Rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_ready", diff_ready, 0);
        chk("arst_valid", sum_valid, 0);
        chk("arst_sum", sum_s(), 0);
        chk("arst_ovf", ovf, 0);
        tick();
        Rst = 1'b1;
        diff_valid = 1'b1;
        repeat (6) begin
            tick();
            chk("post_rst_valid", sum_valid, 0);
            chk("post_rst_busy", busy, 0);
        end
        diff_valid = 1'b0;
        exp_sum = 0; exp_ovf = 1'b0;
        push(-7, 1);
        run_frame(1, 1'b0);
        chk("r37_sum", sum_s(), -7);
        finish_frame(0);

        // Randomized frames
        for (int f = 0; f < 30; f++) begin
            int L;
            int n;
            longint d;
            L = $urandom_range(1, 12);
            n = 0;
            while (n < L) begin
                bit v;
                v = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 3))
                    0: d = longint'($urandom_range(0, 40)) - 20;
                    1: d = 64'sh7FFF_FFFF;
                    2: d = -64'sh8000_0000;
                    default: d = longint'($urandom);
                endcase
                push(d, v);
                if (v) n++;
            end
            run_frame(L, 1'b1);
            finish_frame($urandom_range(0, 3));
        end

        // Maximum length frame
        repeat (255) push(-1, 1);
        run_frame(255, 1'b0);
        chk("r38_sum", sum_s(), -255);
        chk("r38_ovf", ovf, 0);
        finish_frame(0);
        tick();
        chk("r38_no_wrap", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
